// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared arm controller defaults and sequencer state type
package arm_ctrl_pkg;

  localparam int DEF_N_JOINTS    = 6;
  localparam int DEF_DUTY_W      = 8;
  localparam int DEF_DUTY_CENTER = 128;
  localparam int DEF_DUTY_MIN    = 32;
  localparam int DEF_DUTY_MAX    = 224;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } seq_state_t;

endpackage

// File: rtl/arm_tick_gen.sv
// rtl/arm_tick_gen.sv - free-running divider producing a single-cycle update tick
module arm_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // Count 0..TICK_DIV-1 and wrap; keeps running while the sequencer sweeps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/arm_pose_sequencer.sv
// rtl/arm_pose_sequencer.sv - clamps joint targets and ramps live duty words per tick
module arm_pose_sequencer
  import arm_ctrl_pkg::*;
#(
  parameter int N_JOINTS    = DEF_N_JOINTS,
  parameter int DUTY_W      = DEF_DUTY_W,
  parameter int DUTY_CENTER = DEF_DUTY_CENTER,
  parameter int DUTY_MIN    = DEF_DUTY_MIN,
  parameter int DUTY_MAX    = DEF_DUTY_MAX,
  parameter int STEP        = 4,
  parameter int TICK_DIV    = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_joint,
  input  logic [DUTY_W-1:0]            cmd_target,
  output logic                         cmd_err,
  output logic [N_JOINTS*DUTY_W-1:0]   duty_out,
  output logic [N_JOINTS-1:0]          moving,
  output logic                         all_done
);

  localparam int IDX_W = (N_JOINTS > 1) ? $clog2(N_JOINTS) : 1;
  localparam logic [DUTY_W-1:0] D_CENTER = DUTY_W'(DUTY_CENTER);
  localparam logic [DUTY_W-1:0] D_MIN    = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] D_MAX    = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W:0]   D_STEP   = (DUTY_W + 1)'(STEP);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_JOINTS - 1);

  seq_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [DUTY_W-1:0] duty   [N_JOINTS];
  logic [DUTY_W-1:0] target [N_JOINTS];

  logic              tick;
  logic              accept;
  logic              joint_ok;
  logic [DUTY_W-1:0] clamped;
  logic [DUTY_W-1:0] cur_duty;
  logic [DUTY_W-1:0] cur_target;
  logic [DUTY_W-1:0] next_duty;
  logic [DUTY_W:0]   diff;
  logic [DUTY_W:0]   step_amt;

  arm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign joint_ok  = ({1'b0, cmd_joint} < 4'(N_JOINTS));

  // Limit the requested duty to the safe servo window.
  always_comb begin
    clamped = cmd_target;
    if (cmd_target < D_MIN) begin
      clamped = D_MIN;
    end else if (cmd_target > D_MAX) begin
      clamped = D_MAX;
    end
  end

  // Next duty for the joint being swept: move toward target, never past it.
  always_comb begin
    cur_duty   = duty[idx];
    cur_target = target[idx];
    next_duty  = cur_duty;
    diff       = '0;
    step_amt   = '0;
    if (cur_duty < cur_target) begin
      diff      = {1'b0, cur_target} - {1'b0, cur_duty};
      step_amt  = (diff > D_STEP) ? D_STEP : diff;
      next_duty = DUTY_W'({1'b0, cur_duty} + step_amt);
    end else if (cur_duty > cur_target) begin
      diff      = {1'b0, cur_duty} - {1'b0, cur_target};
      step_amt  = (diff > D_STEP) ? D_STEP : diff;
      next_duty = DUTY_W'({1'b0, cur_duty} - step_amt);
    end
  end

  // Sequencer FSM: take commands while idle, update one joint per cycle on a sweep.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      cmd_err <= 1'b0;
      for (int j = 0; j < N_JOINTS; j++) begin
        duty[j]   <= D_CENTER;
        target[j] <= D_CENTER;
      end
    end else begin
      cmd_err <= accept && !joint_ok;
      if (accept && joint_ok) begin
        target[cmd_joint] <= clamped;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
        SWEEP: begin
          duty[idx] <= next_duty;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Pack live duties and flag joints still away from their target.
  always_comb begin
    moving   = '0;
    duty_out = '0;
    for (int j = 0; j < N_JOINTS; j++) begin
      moving[j]                    = (duty[j] != target[j]);
      duty_out[j*DUTY_W +: DUTY_W] = duty[j];
    end
  end

  assign all_done = (moving == '0) && (state == IDLE);

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// tb/tb_arm_pose_sequencer.sv - directed self-checking bench for arm_pose_sequencer
module tb_arm_pose_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_joint = 3'd0;
  logic [7:0]  cmd_target = 8'd0;
  logic        cmd_err;
  logic [47:0] duty_out;
  logic [5:0]  moving;
  logic        all_done;

  int checks = 0;
  int errors = 0;
  int sweep_cnt = 0;
  logic prev_ready = 1'b1;

  typedef struct {
    int   joint;
    int   target;
    int   fin;
    int   ticks;
    logic err;
  } vec_t;

  vec_t vecs [7];

  arm_pose_sequencer #(
    .STEP    (4),
    .TICK_DIV(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_joint (cmd_joint),
    .cmd_target(cmd_target),
    .cmd_err   (cmd_err),
    .duty_out  (duty_out),
    .moving    (moving),
    .all_done  (all_done)
  );

  always #5 clk = ~clk;

  // Count sweeps by the falling edges of cmd_ready.
  always @(posedge clk) begin
    if (prev_ready && !cmd_ready) sweep_cnt <= sweep_cnt + 1;
    prev_ready <= cmd_ready;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] duty_of(input int j);
    return duty_out[j*8 +: 8];
  endfunction

  function automatic logic [47:0] packed_exp(input int j, input int fin);
    logic [47:0] e;
    for (int k = 0; k < 6; k++) e[k*8 +: 8] = (k == j) ? 8'(fin) : 8'd128;
    return e;
  endfunction

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send(input int j, input int t, output logic err1, output logic err2,
                      output logic [5:0] mov1, output int snap);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("send_ready_timeout", 0, 1);
    snap = sweep_cnt;
    cmd_valid = 1'b1;
    cmd_joint = 3'(j);
    cmd_target = 8'(t);
    @(negedge clk);
    cmd_valid = 1'b0;
    err1 = cmd_err;
    mov1 = moving;
    @(negedge clk);
    err2 = cmd_err;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!all_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!all_done) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic e1, e2;
    logic [5:0] m1;
    int snap, n, low, cyc, k, mn, mx;
    logic rdy;

    vecs[0] = '{joint: 2, target: 140, fin: 140, ticks: 3,  err: 1'b0};
    vecs[1] = '{joint: 0, target: 255, fin: 224, ticks: 24, err: 1'b0};
    vecs[2] = '{joint: 1, target: 0,   fin: 32,  ticks: 24, err: 1'b0};
    vecs[3] = '{joint: 7, target: 200, fin: 128, ticks: 0,  err: 1'b1};
    vecs[4] = '{joint: 5, target: 130, fin: 130, ticks: 1,  err: 1'b0};
    vecs[5] = '{joint: 4, target: 128, fin: 128, ticks: 0,  err: 1'b0};
    vecs[6] = '{joint: 3, target: 33,  fin: 33,  ticks: 24, err: 1'b0};

    // Reset state
    do_reset();
    chk("rst_duty", duty_out, packed_exp(0, 128));
    chk("rst_moving", moving, 0);
    chk("rst_all_done", all_done, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cmd_err", cmd_err, 0);

    // Table-driven single commands from a fresh reset
    for (int v = 0; v < 7; v++) begin
      do_reset();
      send(vecs[v].joint, vecs[v].target, e1, e2, m1, snap);
      chk("vec_err_pulse", e1, vecs[v].err);
      chk("vec_err_clear", e2, 0);
      chk("vec_moving", m1, (vecs[v].ticks > 0) ? (6'd1 << vecs[v].joint) : 6'd0);
      if (vecs[v].ticks > 0) begin
        wait_done("vec_done");
        chk("vec_ticks", sweep_cnt - snap, vecs[v].ticks);
        chk("vec_final", duty_of(vecs[v].joint), vecs[v].fin);
        chk("vec_all_duty", duty_out, packed_exp(vecs[v].joint, vecs[v].fin));
      end else begin
        repeat (40) @(negedge clk);
        chk("vec_still_duty", duty_out, packed_exp(0, 128));
        chk("vec_still_moving", moving, 0);
      end
    end

    // Ramp timing: joint 2 updates 3 edges after each tick, ready low 6 cycles
    do_reset();
    send(2, 140, e1, e2, m1, snap);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (cmd_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (cmd_ready) chk("tim_tick_timeout", 0, 1);
      low = 1;
      chk("tim_hold_t0", duty_of(2), 128 + 4 * i);
      @(negedge clk);
      if (!cmd_ready) low++;
      chk("tim_hold_t1", duty_of(2), 128 + 4 * i);
      @(negedge clk);
      if (!cmd_ready) low++;
      chk("tim_hold_t2", duty_of(2), 128 + 4 * i);
      @(negedge clk);
      if (!cmd_ready) low++;
      chk("tim_update_t3", duty_of(2), 132 + 4 * i);
      n = 0;
      while (!cmd_ready && n < 100) begin
        @(negedge clk);
        n++;
        if (!cmd_ready) low++;
      end
      chk("tim_ready_low_cycles", low, 6);
    end
    chk("tim_moving_end", moving, 0);
    chk("tim_all_done_end", all_done, 1);

    // cmd_valid held high across a tick: 14 commands, 6 stalled cycles
    do_reset();
    n = 0;
    while (cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("hold_align_timeout", 0, 1);
    k = 0;
    cyc = 0;
    low = 0;
    while (k < 14 && cyc < 200) begin
      cmd_valid = 1'b1;
      cmd_joint = 3'(k % 6);
      cmd_target = 8'(40 + 10 * k);
      rdy = cmd_ready;
      @(negedge clk);
      cyc++;
      if (rdy) k++;
      else low++;
    end
    cmd_valid = 1'b0;
    chk("hold_total_cycles", cyc, 20);
    chk("hold_stall_cycles", low, 6);
    wait_done("hold_done");
    chk("hold_j0", duty_of(0), 160);
    chk("hold_j1", duty_of(1), 170);
    chk("hold_j2", duty_of(2), 120);
    chk("hold_j3", duty_of(3), 130);
    chk("hold_j4", duty_of(4), 140);
    chk("hold_j5", duty_of(5), 150);

    // Retarget joint 3 mid-ramp: 200 then 100 after five ticks
    do_reset();
    send(3, 200, e1, e2, m1, snap);
    n = 0;
    while (!((sweep_cnt - snap >= 5) && cmd_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("retgt_mid_duty", duty_of(3), 148);
    send(3, 100, e1, e2, m1, snap);
    chk("retgt_err", e1, 0);
    mn = 255;
    mx = 0;
    n = 0;
    while (!all_done && n < 2000) begin
      @(negedge clk);
      n++;
      if (int'(duty_of(3)) < mn) mn = int'(duty_of(3));
      if (int'(duty_of(3)) > mx) mx = int'(duty_of(3));
    end
    if (!all_done) chk("retgt_timeout", 0, 1);
    chk("retgt_ticks", sweep_cnt - snap, 12);
    chk("retgt_final", duty_of(3), 100);
    chk("retgt_min", mn, 100);
    chk("retgt_max", mx, 148);

    // Reset asserted in the middle of a sweep
    do_reset();
    send(0, 224, e1, e2, m1, snap);
    n = 0;
    while (cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("midrst_pre_duty0", duty_of(0), 132);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_duty", duty_out, packed_exp(0, 128));
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_moving", moving, 0);
    chk("midrst_all_done", all_done, 1);
    reset = 1'b1;
    cyc = 0;
    while (cmd_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_first_tick", cyc, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_pose_sequencer.md
# arm_pose_sequencer

Motion sequencer sitting between the command source (host/UART decoder) and the six per-joint PWM generators of the robot arm controller. Accepts per-joint target duty commands over a valid/ready port, clamps them to a safe servo range, and ramps each joint's live duty word toward its target by a bounded step on every update tick, so servos never jump. Outputs the packed duty words that drive the PWM generators, plus per-joint motion status.

## Interface
- N_JOINTS, 6, number of joints (1..8)
- DUTY_W, 8, duty word width
- DUTY_CENTER, 128, reset/neutral duty for every joint
- DUTY_MIN, 32, lowest permitted duty
- DUTY_MAX, 224, highest permitted duty
- STEP, 4, max duty change per joint per tick (1..DUTY_MAX-DUTY_MIN)
- TICK_DIV, 1000, clk cycles per update tick; must be > N_JOINTS+1

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_joint  in  3  joint index
- cmd_target  in  DUTY_W  requested duty
- cmd_err  out  1  one-cycle pulse: accepted command had cmd_joint >= N_JOINTS
- duty_out  out  N_JOINTS*DUTY_W  live duty words, joint j at [j*DUTY_W +: DUTY_W]
- moving  out  N_JOINTS  bit j high while duty[j] != target[j]
- all_done  out  1  no joint moving and FSM in IDLE

## Operation
- State per joint: target[j], duty[j] (registered).
- FSM: IDLE, SWEEP. IDLE -> SWEEP on tick (idx <= 0). SWEEP updates joint idx, idx++; after idx == N_JOINTS-1 -> IDLE.
- cmd_ready = (state == IDLE). Handshake completes on edge with cmd_valid & cmd_ready; valid may stay high, each accepted cycle is one command.
- Accepted command, valid joint: target[joint] <= clamp(cmd_target, DUTY_MIN, DUTY_MAX). Overwrites any in-flight target; ramp continues from current duty.
- Accepted command, invalid joint: no state change, cmd_err high next cycle for exactly one cycle.
- Per-joint update in SWEEP: if duty < target, duty += min(STEP, target-duty); if duty > target, duty -= min(STEP, duty-target); else unchanged. Difference computed at DUTY_W+1 bits; never overshoots or wraps.
- Tick counter: 0..TICK_DIV-1, free-running including during SWEEP; tick = (count == TICK_DIV-1), wraps to 0.
- moving, all_done combinational from registers.

## Timing
- Reset (reset == 0 at edge): duty[j] = target[j] = DUTY_CENTER, count = 0, state IDLE, idx 0, cmd_err 0; hence cmd_ready 1, moving 0, all_done 1. Reset mid-ramp or mid-SWEEP abandons it identically.
- Command accepted at edge E: target visible, moving[j] high after E; no duty change before next tick.
- Tick at edge T: state SWEEP after T; duty[j] updates at edge T+1+j; IDLE after edge T+N_JOINTS; cmd_ready low for exactly N_JOINTS cycles.
- Ramp length from d to t: ceil(|t-d|/STEP) ticks.
- Target equal to current duty: moving stays 0.

## Structure
- Package arm_ctrl_pkg: N_JOINTS, DUTY_W, DUTY_CENTER/MIN/MAX defaults, FSM state type (IDLE, SWEEP), shared with the PWM generator top.
- Sub-module arm_tick_gen: TICK_DIV counter producing single-cycle tick; rest in one module.

## Test plan
- Reset held 3 cycles, released -> all duty_out bytes 128, moving 0, all_done 1, cmd_ready 1.
- TICK_DIV=16, STEP=4: cmd joint 2 target 140 -> moving[2]=1; joint 2 duty 132,136,140 on three successive ticks, each at tick edge+3; then moving[2]=0, all_done=1.
- cmd joint 0 target 255 and joint 1 target 0 -> targets clamp to 224/32; ramps stop exactly at 224 and 32.
- cmd joint 7 (N_JOINTS=6) -> cmd_err one-cycle pulse, no target/duty changes.
- cmd_valid held high across a tick -> cmd_ready low for exactly 6 cycles, no command lost or double-accepted; retarget joint 3 from 200 to 100 mid-ramp -> ramp reverses from current duty without overshoot.
- Assert reset mid-SWEEP -> next cycle all duty 128, state IDLE, count restarts at 0.
